// File: rtl/regfile_wb_sink_pkg.sv
// Shared constants, types and helpers for the register file, its scoreboard
// and the pipeline stages that feed it.
package regfile_wb_sink_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_TAG_WIDTH  = 3;
    localparam int RF_NUM_REGS   = 32;
    localparam int REG_IDX_W     = 5;
    localparam int WB_ADDR_W     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Instruction identifiers shared by decode and writeback.
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK
    } opcode_e;

    // Only x0..x31 are addressable; any upper bit set is an illegal target.
    function automatic logic wb_addr_legal(input logic [WB_ADDR_W-1:0] addr);
        return addr[WB_ADDR_W-1:REG_IDX_W] == '0;
    endfunction

endpackage

// File: rtl/regfile_wb_sink_if.sv
// Writeback bus from the writeback stage into the register file.
// wb_en qualifies the beat; the sink has no back-pressure, so every cycle with wb_en high is a transfer.
interface regfile_wb_sink_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 3
);
    logic                  wb_en;
    logic [DATA_WIDTH-1:0] wb_out;
    logic [31:0]           wb_addr;
    logic [TAG_WIDTH-1:0]  wb_tag;

    modport master (output wb_en, wb_out, wb_addr, wb_tag);
    modport slave  (input  wb_en, wb_out, wb_addr, wb_tag);
endinterface

// File: rtl/regfile_wb_sink_scoreboard.sv
// Busy/tag scoreboard: set at issue, cleared by a writeback carrying the
// matching tag, wiped on flush. Busy reads are registered.
module regfile_scoreboard
    import regfile_wb_sink_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 issue_en,
    input  reg_idx_t             issue_rd,
    input  logic [TAG_WIDTH-1:0] issue_tag,
    input  logic                 wb_commit,
    input  reg_idx_t             wb_idx,
    input  logic [TAG_WIDTH-1:0] wb_tag,
    input  reg_idx_t             rs1_addr,
    input  reg_idx_t             rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    logic [NUM_REGS-1:0]  busy;
    logic [TAG_WIDTH-1:0] tags [NUM_REGS];
    logic                 clear_hit;
    logic                 issue_set;
    logic                 busy1_next;
    logic                 busy2_next;

    // An older producer (tag mismatch) must not clear a newer reservation.
    assign clear_hit = wb_commit && busy[wb_idx] && (tags[wb_idx] == wb_tag);
    assign issue_set = issue_en && !flush && (issue_rd != '0);

    always_comb begin
        busy1_next = (rs1_addr != '0) && busy[rs1_addr] && !(clear_hit && (wb_idx == rs1_addr));
        busy2_next = (rs2_addr != '0) && busy[rs2_addr] && !(clear_hit && (wb_idx == rs2_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            rs1_busy <= 1'b0;
            rs2_busy <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
        end else begin
            rs1_busy <= busy1_next;
            rs2_busy <= busy2_next;
            if (flush) begin
                busy <= '0;
            end else begin
                if (clear_hit) busy[wb_idx] <= 1'b0;
                // Issued after the clear so a same-register issue wins.
                if (issue_set) begin
                    busy[issue_rd] <= 1'b1;
                    tags[issue_rd] <= issue_tag;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural register file terminating the writeback bus, with a busy/tag
// scoreboard and two registered, write-bypassed read ports for issue.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int TAG_WIDTH  = RF_TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_sink_if.slave       wb,
    input  logic                   flush,
    input  logic                   issue_en,
    input  logic [4:0]             issue_rd,
    input  logic [TAG_WIDTH-1:0]   issue_tag,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    output logic [DATA_WIDTH-1:0]  rs1_data,
    output logic [DATA_WIDTH-1:0]  rs2_data,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   wb_addr_err
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    reg_idx_t              wb_idx;
    logic                  wb_legal;
    logic                  wb_commit;
    logic [DATA_WIDTH-1:0] rd1_next;
    logic [DATA_WIDTH-1:0] rd2_next;

    assign wb_idx    = wb.wb_addr[REG_IDX_W-1:0];
    assign wb_legal  = wb.wb_en && wb_addr_legal(wb.wb_addr);
    // Address 0 is what writeback drives for non-writing instructions.
    assign wb_commit = wb_legal && (wb_idx != '0);

    always_comb begin
        rd1_next = regs[rs1_addr];
        if (rs1_addr == '0)                       rd1_next = '0;
        else if (wb_commit && wb_idx == rs1_addr) rd1_next = wb.wb_out;

        rd2_next = regs[rs2_addr];
        if (rs2_addr == '0)                       rd2_next = '0;
        else if (wb_commit && wb_idx == rs2_addr) rd2_next = wb.wb_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data    <= '0;
            rs2_data    <= '0;
            wb_addr_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            rs1_data    <= rd1_next;
            rs2_data    <= rd2_next;
            wb_addr_err <= wb.wb_en && !wb_addr_legal(wb.wb_addr);
            if (wb_commit) regs[wb_idx] <= wb.wb_out;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .issue_tag (issue_tag),
        .wb_commit (wb_commit),
        .wb_idx    (wb_idx),
        .wb_tag    (wb.wb_tag),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink: table of single-cycle vectors plus
// hand-written reset sequences.
module tb_regfile_wb_sink;

    localparam int DW = 32;
    localparam int TW = 3;
    localparam int EW = 2 * DW + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_sink_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) wb_bus ();

    logic          flush;
    logic          issue_en;
    logic [4:0]    issue_rd;
    logic [TW-1:0] issue_tag;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          wb_addr_err;

    regfile_wb_sink #(.DATA_WIDTH(DW), .NUM_REGS(32), .TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wb_bus),
        .flush       (flush),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_tag   (issue_tag),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wb_addr_err (wb_addr_err)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic          wb_en;
        logic [DW-1:0] wb_out;
        logic [31:0]   wb_addr;
        logic [TW-1:0] wb_tag;
        logic          flush;
        logic          issue_en;
        logic [4:0]    issue_rd;
        logic [TW-1:0] issue_tag;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [DW-1:0] e_rs1;
        logic [DW-1:0] e_rs2;
        logic          e_b1;
        logic          e_b2;
        logic          e_err;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic en, input logic [31:0] d, input logic [31:0] a,
                                input logic [2:0] t, input logic fl, input logic ie,
                                input logic [4:0] ird, input logic [2:0] itag,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic b1, input logic b2, input logic err);
        vec_t v;
        v.wb_en = en; v.wb_out = d; v.wb_addr = a; v.wb_tag = t;
        v.flush = fl; v.issue_en = ie; v.issue_rd = ird; v.issue_tag = itag;
        v.rs1 = r1; v.rs2 = r2;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_err = err;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".rs1_data"}, rs1_data, e[EW-1 -: DW]);
        check({tag, ".rs2_data"}, rs2_data, e[EW-DW-1 -: DW]);
        check({tag, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, e[2]});
        check({tag, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, e[1]});
        check({tag, ".wb_addr_err"}, {31'd0, wb_addr_err}, {31'd0, e[0]});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        wb_bus.wb_en   = v.wb_en;
        wb_bus.wb_out  = v.wb_out;
        wb_bus.wb_addr = v.wb_addr;
        wb_bus.wb_tag  = v.wb_tag;
        flush          = v.flush;
        issue_en       = v.issue_en;
        issue_rd       = v.issue_rd;
        issue_tag      = v.issue_tag;
        rs1_addr       = v.rs1;
        rs2_addr       = v.rs2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(mk(0, 32'h0, 32'h0, 3'd0, 0, 0, 5'd0, 3'd0, r1, r2, 32'h0, 32'h0, 0, 0, 0));
    endtask

    initial begin
        // Sequential dependencies: each row sees the state left by the rows above.
        //            en  wb_out         wb_addr      tag  fl ie  ird   itag  rs1    rs2    e_rs1          e_rs2          b1 b2 err
        vecs[0]  = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd5,  5'd0,  32'h0,         32'h0,         0, 0, 0);
        vecs[1]  = mk(1, 32'hDEADBEEF, 32'd7,       3'd0, 0, 0, 5'd0, 3'd0, 5'd7,  5'd0,  32'hDEADBEEF,  32'h0,         0, 0, 0);
        vecs[2]  = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd7,  5'd7,  32'hDEADBEEF,  32'hDEADBEEF,  0, 0, 0);
        vecs[3]  = mk(1, 32'h1234,     32'd0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd0,  5'd7,  32'h0,         32'hDEADBEEF,  0, 0, 0);
        vecs[4]  = mk(1, 32'h5555,     32'h25,      3'd0, 0, 0, 5'd0, 3'd0, 5'd5,  5'd0,  32'h0,         32'h0,         0, 0, 1);
        vecs[5]  = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd5,  5'd0,  32'h0,         32'h0,         0, 0, 0);
        vecs[6]  = mk(0, 32'h0,        32'h0,       3'd0, 0, 1, 5'd3, 3'd1, 5'd3,  5'd3,  32'h0,         32'h0,         0, 0, 0);
        vecs[7]  = mk(0, 32'h0,        32'h0,       3'd0, 0, 1, 5'd3, 3'd2, 5'd3,  5'd0,  32'h0,         32'h0,         1, 0, 0);
        vecs[8]  = mk(1, 32'h11,       32'd3,       3'd1, 0, 0, 5'd0, 3'd0, 5'd3,  5'd3,  32'h11,        32'h11,        1, 1, 0);
        vecs[9]  = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd3,  5'd0,  32'h11,        32'h0,         1, 0, 0);
        vecs[10] = mk(1, 32'h22,       32'd3,       3'd2, 0, 0, 5'd0, 3'd0, 5'd3,  5'd0,  32'h22,        32'h0,         0, 0, 0);
        vecs[11] = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd3,  5'd0,  32'h22,        32'h0,         0, 0, 0);
        vecs[12] = mk(0, 32'h0,        32'h0,       3'd0, 0, 1, 5'd4, 3'd3, 5'd4,  5'd0,  32'h0,         32'h0,         0, 0, 0);
        vecs[13] = mk(1, 32'h44,       32'd4,       3'd3, 0, 1, 5'd4, 3'd5, 5'd4,  5'd0,  32'h44,        32'h0,         0, 0, 0);
        vecs[14] = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd4,  5'd0,  32'h44,        32'h0,         1, 0, 0);
        vecs[15] = mk(1, 32'h45,       32'd4,       3'd3, 0, 0, 5'd0, 3'd0, 5'd4,  5'd0,  32'h45,        32'h0,         1, 0, 0);
        vecs[16] = mk(1, 32'h46,       32'd4,       3'd5, 0, 0, 5'd0, 3'd0, 5'd4,  5'd0,  32'h46,        32'h0,         0, 0, 0);
        vecs[17] = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd4,  5'd0,  32'h46,        32'h0,         0, 0, 0);
        vecs[18] = mk(0, 32'h0,        32'h0,       3'd0, 0, 1, 5'd1, 3'd0, 5'd1,  5'd0,  32'h0,         32'h0,         0, 0, 0);
        vecs[19] = mk(0, 32'h0,        32'h0,       3'd0, 0, 1, 5'd2, 3'd1, 5'd1,  5'd0,  32'h0,         32'h0,         1, 0, 0);
        vecs[20] = mk(0, 32'h0,        32'h0,       3'd0, 0, 1, 5'd9, 3'd2, 5'd2,  5'd1,  32'h0,         32'h0,         1, 1, 0);
        vecs[21] = mk(1, 32'h77,       32'd2,       3'd7, 1, 1, 5'd10, 3'd3, 5'd0, 5'd5,  32'h0,         32'h0,         0, 0, 0);
        vecs[22] = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd2,  5'd10, 32'h77,        32'h0,         0, 0, 0);
        vecs[23] = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd1,  5'd9,  32'h0,         32'h0,         0, 0, 0);
        vecs[24] = mk(1, 32'hA5A5A5A5, 32'd1,       3'd0, 0, 0, 5'd0, 3'd0, 5'd1,  5'd2,  32'hA5A5A5A5,  32'h77,        0, 0, 0);
        vecs[25] = mk(1, 32'hFFFF0000, 32'd31,      3'd0, 0, 0, 5'd0, 3'd0, 5'd31, 5'd31, 32'hFFFF0000,  32'hFFFF0000,  0, 0, 0);
        vecs[26] = mk(0, 32'h99,       32'h45,      3'd0, 0, 0, 5'd0, 3'd0, 5'd5,  5'd0,  32'h0,         32'h0,         0, 0, 0);
        vecs[27] = mk(0, 32'h0,        32'h0,       3'd0, 0, 0, 5'd0, 3'd0, 5'd5,  5'd31, 32'h0,         32'hFFFF0000,  0, 0, 0);

        // Reset: asserted with no clock edge, outputs must already be zero.
        rst_n = 1'b1;
        wb_bus.wb_en = 1'b0; wb_bus.wb_out = '0; wb_bus.wb_addr = '0; wb_bus.wb_tag = '0;
        flush = 1'b0; issue_en = 1'b0; issue_rd = '0; issue_tag = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1 rst_n = 1'b0;
        #2;
        exp_q.push_back('0);
        check_outputs("reset_initial");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            exp_q.push_back({vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_err});
            drive(vecs[i]);
            check_outputs($sformatf("vec%0d", i));
        end

        // Load every output with a non-zero value, then reset between edges.
        drive(mk(0, 32'h0, 32'h0, 3'd0, 0, 1, 5'd31, 3'd1, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 0));
        drive(mk(1, 32'h5A5A, 32'h100, 3'd0, 0, 0, 5'd0, 3'd0, 5'd31, 5'd31, 32'h0, 32'h0, 0, 0, 0));
        exp_q.push_back({32'hFFFF0000, 32'hFFFF0000, 1'b1, 1'b1, 1'b1});
        check_outputs("pre_reset");
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        check_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(5'd31, 5'd7);
        exp_q.push_back('0);
        check_outputs("post_reset");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: %0d expected entries left", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
